// File: rtl/transmissor_frame_menu.sv
// ---------------------------------------------------------------------------
// transmissor_frame_menu
//
// Downstream stage of the menu control unit. On an envia_dados pulse it
// snapshots the screen code and the score, then serialises them as a framed
// UART 8N1 message (LSB first, idle high) towards the host PC renderer.
// The bit-timing serialiser lives inside this block.
//
// Frame bytes, in order: CABECALHO, tela, pontuacao[15:8], pontuacao[7:0]
// and, when the macro FRAME_CHECKSUM_EN is defined, a fifth byte holding the
// XOR of the four previous bytes. Without the macro the frame has 4 bytes
// and no checksum logic exists.
//
// Parameters:
//   CICLOS_POR_BIT  clock cycles per UART bit (>= 2)
//   CABECALHO       first byte of every frame
//
// Ports:
//   clock             system clock, rising edge
//   reset             asynchronous active-low reset
//   envia_dados       one-cycle start request (ignored while ocupado)
//   tela_renderizada  screen code to send
//   pontuacao         current score, unsigned
//   saida_serial      UART TX line (registered)
//   fim_envia_dados   one-cycle pulse once the last stop bit has ended
//   ocupado           high from capture through the fim_envia_dados cycle
//   db_estado         current state: 0 ocioso, 1 bit_inicio, 2 bits_dados,
//                     3 bit_parada, 4 fim
//
// Handshake: envia_dados is sampled only in ocioso; a request seen on a
// rising edge while ocupado=0 is accepted on that same edge, any other
// request is dropped (never queued). fim_envia_dados is a single-cycle
// completion strobe with no acknowledge.
// ---------------------------------------------------------------------------
module transmissor_frame_menu #(
  parameter int         CICLOS_POR_BIT = 434,
  parameter logic [7:0] CABECALHO      = 8'hAA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        envia_dados,
  input  logic [7:0]  tela_renderizada,
  input  logic [15:0] pontuacao,
  output logic        saida_serial,
  output logic        fim_envia_dados,
  output logic        ocupado,
  output logic [2:0]  db_estado
);

  localparam int CW = $clog2(CICLOS_POR_BIT);
  localparam logic [CW-1:0] ULTIMO_CICLO = CW'(CICLOS_POR_BIT - 1);

`ifdef FRAME_CHECKSUM_EN
  localparam logic [2:0] ULTIMO_BYTE = 3'd4;
`else
  localparam logic [2:0] ULTIMO_BYTE = 3'd3;
`endif

  localparam logic [2:0] OCIOSO     = 3'd0;
  localparam logic [2:0] BIT_INICIO = 3'd1;
  localparam logic [2:0] BITS_DADOS = 3'd2;
  localparam logic [2:0] BIT_PARADA = 3'd3;
  localparam logic [2:0] FIM        = 3'd4;

  logic [2:0]    estado;
  logic [CW-1:0] contador_ciclo;
  logic [2:0]    indice_bit;
  logic [2:0]    indice_byte;
  logic [7:0]    tela_capturada;
  logic [15:0]   pontuacao_capturada;
  logic [7:0]    byte_atual;
  logic          fim_do_bit;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = CABECALHO ^ tela_capturada ^ pontuacao_capturada[15:8]
                    ^ pontuacao_capturada[7:0];
`endif

  // Byte currently being shifted, selected from the captured snapshot so
  // input changes after capture never reach the line.
  always_comb begin
    byte_atual = CABECALHO;
    case (indice_byte)
      3'd0:    byte_atual = CABECALHO;
      3'd1:    byte_atual = tela_capturada;
      3'd2:    byte_atual = pontuacao_capturada[15:8];
      3'd3:    byte_atual = pontuacao_capturada[7:0];
`ifdef FRAME_CHECKSUM_EN
      3'd4:    byte_atual = checksum;
`endif
      default: byte_atual = CABECALHO;
    endcase
  end

  assign fim_do_bit = (contador_ciclo == ULTIMO_CICLO);
  assign db_estado  = estado;

  // saida_serial is loaded with the level of the *next* cycle on every
  // transition, so the line changes exactly on the edge that ends a bit
  // and is driven straight from a flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado              <= OCIOSO;
      contador_ciclo      <= '0;
      indice_bit          <= '0;
      indice_byte         <= '0;
      tela_capturada      <= '0;
      pontuacao_capturada <= '0;
      saida_serial        <= 1'b1;
      fim_envia_dados     <= 1'b0;
      ocupado             <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          saida_serial    <= 1'b1;
          fim_envia_dados <= 1'b0;
          ocupado         <= 1'b0;
          if (envia_dados) begin
            tela_capturada      <= tela_renderizada;
            pontuacao_capturada <= pontuacao;
            contador_ciclo      <= '0;
            indice_bit          <= '0;
            indice_byte         <= '0;
            saida_serial        <= 1'b0;
            ocupado             <= 1'b1;
            estado              <= BIT_INICIO;
          end
        end

        BIT_INICIO: begin
          if (fim_do_bit) begin
            contador_ciclo <= '0;
            indice_bit     <= '0;
            saida_serial   <= byte_atual[0];
            estado         <= BITS_DADOS;
          end else begin
            contador_ciclo <= contador_ciclo + 1'b1;
          end
        end

        BITS_DADOS: begin
          if (fim_do_bit) begin
            contador_ciclo <= '0;
            if (indice_bit == 3'd7) begin
              saida_serial <= 1'b1;
              estado       <= BIT_PARADA;
            end else begin
              indice_bit   <= indice_bit + 3'd1;
              saida_serial <= byte_atual[indice_bit + 3'd1];
            end
          end else begin
            contador_ciclo <= contador_ciclo + 1'b1;
          end
        end

        BIT_PARADA: begin
          if (fim_do_bit) begin
            contador_ciclo <= '0;
            if (indice_byte == ULTIMO_BYTE) begin
              saida_serial    <= 1'b1;
              fim_envia_dados <= 1'b1;
              estado          <= FIM;
            end else begin
              // Next start bit follows immediately: no inter-byte gap.
              indice_byte  <= indice_byte + 3'd1;
              saida_serial <= 1'b0;
              estado       <= BIT_INICIO;
            end
          end else begin
            contador_ciclo <= contador_ciclo + 1'b1;
          end
        end

        FIM: begin
          saida_serial    <= 1'b1;
          fim_envia_dados <= 1'b0;
          ocupado         <= 1'b0;
          estado          <= OCIOSO;
        end

        default: begin
          contador_ciclo  <= '0;
          saida_serial    <= 1'b1;
          fim_envia_dados <= 1'b0;
          ocupado         <= 1'b0;
          estado          <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: doc/transmissor_frame_menu.md
Name: transmissor_frame_menu

Overview:
Downstream stage of the menu control unit. On an `envia_dados` pulse it snapshots the screen code and the current score, and serialises them as a framed UART message to the host PC, where the Python renderer runs. It signals `fim_envia_dados` back to the control unit when the last stop bit has left the line. The UART bit-timing serialiser is built into this block; there is no separate UART instance.

Parameters:
- CICLOS_POR_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); minimum 2.
- CABECALHO, 8'hAA, first byte of every frame.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- envia_dados  input  1  one-cycle start request from the menu control unit.
- tela_renderizada  input  8  screen code to send (1..4).
- pontuacao  input  16  current score, unsigned.
- saida_serial  output  1  UART TX line, 8N1, LSB first, idle high.
- fim_envia_dados  output  1  one-cycle pulse when the frame is complete.
- ocupado  output  1  high from capture until the `fim_envia_dados` cycle, inclusive.
- db_estado  output  3  current state encoding, for debug.

Behaviour:
- Reset (reset=0, asynchronous) forces the following:
  - state = ocioso;
  - saida_serial=1, fim_envia_dados=0, ocupado=0;
  - bit counter, byte index and cycle counters cleared;
  - capture registers cleared.
- Reset mid-frame aborts the frame. The line returns high immediately and no `fim_envia_dados` is issued.
- Frame bytes, in transmission order:
  - CABECALHO;
  - tela_renderizada;
  - pontuacao[15:8];
  - pontuacao[7:0];
  - checksum (only if FRAME_CHECKSUM_EN is defined).
- Capture: in ocioso, `envia_dados`=1 at a rising edge latches `tela_renderizada` and `pontuacao`. The state goes to bit_inicio, and `ocupado` rises on that same edge.
- `envia_dados` while `ocupado`=1 is ignored. It is neither queued nor a restart.
- Input changes after capture do not affect the frame in flight.
- State machine (db_estado encoding in parentheses):
  - ocioso (0): saida_serial=1. Go to bit_inicio on `envia_dados`.
  - bit_inicio (1): saida_serial=0 for CICLOS_POR_BIT cycles, then go to bits_dados.
  - bits_dados (2): drives byte[i] for i=0..7, each for CICLOS_POR_BIT cycles, then go to bit_parada.
  - bit_parada (3): saida_serial=1 for CICLOS_POR_BIT cycles. Then:
    - if another byte remains, increment the byte index and go to bit_inicio (zero inter-byte gap);
    - otherwise go to fim.
  - fim (4): fim_envia_dados=1 and saida_serial=1 for exactly one cycle, then go to ocioso (`ocupado` falls).
  - Unused encodings go to ocioso.
- Timing:
  - The first start bit is driven in the first cycle after the capture edge.
  - `fim_envia_dados` is asserted exactly N×10×CICLOS_POR_BIT cycles after the capture edge (N = 4 or 5).
- A new `envia_dados` may be accepted in the cycle after fim, i.e. once back in ocioso.
- Cycle counter: counts 0..CICLOS_POR_BIT-1 and wraps, width $clog2(CICLOS_POR_BIT). The bit and byte indices advance only on wrap.
- All outputs are registered; saida_serial has no combinational glitches.

Optional Feature:
- FRAME_CHECKSUM_EN defined:
  - a fifth byte is appended: XOR of CABECALHO, tela, pont_hi and pont_lo;
  - N=5, frame = 50×CICLOS_POR_BIT cycles.
- FRAME_CHECKSUM_EN undefined:
  - the frame ends after pontuacao[7:0];
  - N=4, frame = 40×CICLOS_POR_BIT cycles;
  - no checksum logic is synthesised.

Test Plan:
- Basic frame, CICLOS_POR_BIT=4, no checksum:
  - stimulus: tela=1, pontuacao=16'h1234, `envia_dados` pulse;
  - required response: line decodes AA,01,12,34;
  - `fim_envia_dados` pulses once, exactly 160 cycles after capture;
  - `ocupado` is high for 161 cycles.
- Checksum frame, FRAME_CHECKSUM_EN, CICLOS_POR_BIT=4:
  - stimulus: tela=3, pontuacao=16'h00FF;
  - required response: bytes AA,03,00,FF,56 (AA^03^00^FF=56);
  - fim pulses at cycle 200.
- Busy rejection:
  - stimulus: second `envia_dados` with tela=4 at cycle 50 of a frame carrying tela=2;
  - required response: only one frame, tela byte = 02, a single fim pulse;
  - stimulus: a pulse in the cycle after fim;
  - required response: a new frame is started.
- Input stability:
  - stimulus: change pontuacao from 16'h0005 to 16'h0999 at cycle 10 of the frame;
  - required response: transmitted score bytes are 00,05.
- Reset mid-frame:
  - stimulus: reset=0 during the tela byte;
  - required response: saida_serial=1 within the same cycle (asynchronous);
  - no fim pulse;
  - after reset release, a new request produces a correct full frame.
- Bit timing:
  - stimulus: CICLOS_POR_BIT=434 (default), run one frame;
  - required response: every bit level is held exactly 434 cycles;
  - start bit is low, stop bit is high, data is LSB first.
